// File: rtl/step_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// step_sequencer_ctrl
//
// Run / pause / single-step controller for the LED state machine. Instead of
// clocking the state machine from a divided clock, this block emits a
// one-cycle advance enable (step_en) at a selectable rate, counts the steps
// it has issued and optionally stops after a programmed number of steps.
//
// Ports
//   clk         in   1      system clock, all logic on the rising edge
//   rst_a       in   1      synchronous, active-high reset
//   cmd_run     in   1      start / resume free-running steps
//   cmd_pause   in   1      hold in PAUSE, no steps
//   cmd_step    in   1      request exactly one step (IDLE / PAUSE only)
//   cmd_stop    in   1      abort to IDLE and clear step_count
//   rate_sel    in   2      step period = DIV_BASE << rate_sel
//   step_en     out  1      registered one-cycle advance pulse
//   running     out  1      high while in RUN
//   done        out  1      high while in DONE
//   step_count  out  CNT_W  steps issued since the last stop / reset
//
// Command priority within a cycle: stop > pause > run > step.
// -----------------------------------------------------------------------------
module step_sequencer_ctrl #(
    parameter int DIV_BASE  = 50_000_000,
    parameter int PRE_W     = 32,
    parameter int CNT_W     = 8,
    parameter int MAX_STEPS = 0
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             cmd_run,
    input  logic             cmd_pause,
    input  logic             cmd_step,
    input  logic             cmd_stop,
    input  logic [1:0]       rate_sel,
    output logic             step_en,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg,      state_next;
    logic [PRE_W-1:0]   tick_cnt_reg,   tick_cnt_next;
    logic [CNT_W-1:0]   step_count_reg, step_count_next;
    logic               step_en_reg,    step_en_next;
    logic               running_reg;
    logic               done_reg;

    logic [PRE_W-1:0]   period_m1;
    logic [CNT_W-1:0]   count_inc;
    logic               issue_step;
    logic               limit_hit;

    // rate_sel is applied live; the terminal compare below is ">=" so that a
    // shorter period selected mid-count fires on the next cycle instead of
    // waiting for the prescaler to wrap.
    assign period_m1 = (PRE_W'(DIV_BASE) << rate_sel) - PRE_W'(1);
    assign count_inc = step_count_reg + CNT_W'(1);
    assign limit_hit = (MAX_STEPS != 0) && (count_inc == CNT_W'(MAX_STEPS));

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        step_count_next = step_count_reg;
        issue_step      = 1'b0;

        if (cmd_stop) begin
            state_next      = IDLE;
            tick_cnt_next   = '0;
            step_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A pause in IDLE only masks the lower-priority run/step.
                    if (cmd_pause) begin
                        state_next = IDLE;
                    end else if (cmd_run) begin
                        state_next    = RUN;
                        tick_cnt_next = '0;
                    end else if (cmd_step) begin
                        issue_step = 1'b1;
                        state_next = PAUSE;
                    end
                end
                RUN: begin
                    // Pause wins even at terminal count: that step is dropped.
                    if (cmd_pause) begin
                        state_next    = PAUSE;
                        tick_cnt_next = '0;
                    end else if (tick_cnt_reg >= period_m1) begin
                        tick_cnt_next = '0;
                        issue_step    = 1'b1;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    if (cmd_pause) begin
                        state_next = PAUSE;
                    end else if (cmd_run) begin
                        // Prescaler restarts so the first step comes a full period later.
                        state_next    = RUN;
                        tick_cnt_next = '0;
                    end else if (cmd_step) begin
                        issue_step = 1'b1;
                    end
                end
                default: begin
                    // DONE: only stop or reset leave.
                    state_next = DONE;
                end
            endcase

            // Count is registered on the same edge as step_en so both are
            // visible together; the final step also lands in DONE on that edge.
            if (issue_step) begin
                step_count_next = count_inc;
                if (limit_hit) begin
                    state_next    = DONE;
                    tick_cnt_next = '0;
                end
            end
        end

        step_en_next = issue_step;
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            step_count_reg <= '0;
            step_en_reg    <= 1'b0;
            running_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            step_count_reg <= step_count_next;
            step_en_reg    <= step_en_next;
            running_reg    <= (state_next == RUN);
            done_reg       <= (state_next == DONE);
        end
    end

    assign step_en    = step_en_reg;
    assign running    = running_reg;
    assign done       = done_reg;
    assign step_count = step_count_reg;

endmodule
